jelly_uart_rx_fifo: RTL and testbench

Receive buffer placed directly downstream of the UART receiver. It captures the receiver's single-cycle byte strobes, which cannot be back-pressured, into a small first-word-fall-through FIFO. It presents the bytes to the bus/CPU side on a valid/ready stream and reports occupancy, a threshold interrupt, and overrun status, so that no byte is lost silently when the consumer stalls.

---
 rtl/jelly_uart_rx_fifo.sv | 107 ++++++++++
 tb/tb_jelly_uart_rx_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_uart_rx_fifo.sv
// UART receive FIFO: captures non-stallable byte strobes into a
// first-word-fall-through buffer with occupancy, irq and overrun status.
// Ports: clk, reset_n | s_data/s_valid (write strobe) |
//   m_data/m_valid/m_ready (stream out) | fifo_count, irq_level,
//   overrun, drop_count | status_clear, flush (synchronous controls).
module jelly_uart_rx_fifo #(
  parameter int PTR_WIDTH  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int THRESHOLD  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PTR_WIDTH:0]    fifo_count,
  output logic                  irq_level,
  output logic                  overrun,
  output logic [7:0]            drop_count,
  input  logic                  status_clear,
  input  logic                  flush
);

  localparam int DEPTH = 1 << PTR_WIDTH;

  localparam logic [PTR_WIDTH:0] CNT_FULL =
    (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] CNT_THR =
    (PTR_WIDTH+1)'(THRESHOLD);
  localparam logic [PTR_WIDTH:0] CNT_ONE =
    (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE =
    PTR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH:0]    count;

  logic full;
  logic pop;
  logic push;
  logic drop;

  assign full = (count == CNT_FULL);
  assign pop  = m_valid & m_ready;
  // A pop frees the slot in the same cycle, so full+pop still accepts.
  assign push = s_valid & (~full | pop);
  // Flush discards the incoming byte silently, so it is not a drop.
  assign drop = s_valid & full & ~pop & ~flush;

  assign m_data     = mem[rd_ptr];
  assign m_valid    = (count != '0);
  assign fifo_count = count;
  assign irq_level  = (count >= CNT_THR);

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case (1'b1)
        push && !pop: count <= count + CNT_ONE;
        pop && !push: count <= count - CNT_ONE;
        default:      count <= count;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins: status restarts at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (status_clear) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (status_clear) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_jelly_uart_rx_fifo.sv
// Testbench for jelly_uart_rx_fifo: queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_jelly_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] fifo_count;
  logic       irq_level;
  logic       overrun;
  logic [7:0] drop_count;
  logic       status_clear;
  logic       flush;

  int n_chk;
  int n_fail;

  jelly_uart_rx_fifo #(
    .PTR_WIDTH (4),
    .DATA_WIDTH(8),
    .THRESHOLD (8)
  ) dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .fifo_count  (fifo_count),
    .irq_level   (irq_level),
    .overrun     (overrun),
    .drop_count  (drop_count),
    .status_clear(status_clear),
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference model: a plain byte queue plus status values.
  logic [7:0] mq[$];
  bit         m_ovr;
  int         m_drops;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovr   = 1'b0;
      m_drops = 0;
    end else begin
      int n;
      bit p;
      bit d;
      n = mq.size();
      p = (n > 0) && m_ready;
      d = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        if (p) void'(mq.pop_front());
        if (s_valid) begin
          if (n < 16 || p) mq.push_back(s_data);
          else d = 1'b1;
        end
      end
      if (d) begin
        m_ovr = 1'b1;
        if (status_clear) m_drops = 1;
        else if (m_drops < 255) m_drops++;
      end else if (status_clear) begin
        m_ovr   = 1'b0;
        m_drops = 0;
      end
    end
  end

  always @(negedge clk) begin
    int n;
    n = mq.size();
    chk("m_valid", 32'(m_valid), 32'(n != 0));
    if (n != 0) chk("m_data", 32'(m_data), 32'(mq[0]));
    chk("fifo_count", 32'(fifo_count), 32'(n));
    chk("irq_level", 32'(irq_level), 32'(n >= 8));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
  end

  // Collected output stream for the wrap test.
  logic [7:0] outq[$];
  bit         collect;
  always @(posedge clk) begin
    if (collect && m_valid && m_ready) outq.push_back(m_data);
  end

  task automatic step(input bit sv, input logic [7:0] sd,
                      input bit rdy, input bit clr = 1'b0,
                      input bit fl = 1'b0);
    s_valid      = sv;
    s_data       = sd;
    m_ready      = rdy;
    status_clear = clr;
    flush        = fl;
    @(posedge clk);
    #1;
    s_valid      = 1'b0;
    m_ready      = 1'b0;
    status_clear = 1'b0;
    flush        = 1'b0;
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    collect      = 1'b0;
    rst_n        = 1'b0;
    s_data       = 8'h00;
    s_valid      = 1'b0;
    m_ready      = 1'b0;
    status_clear = 1'b0;
    flush        = 1'b0;

    // Reset / basic
    #3;
    chk("rst m_valid", 32'(m_valid), 0);
    chk("rst count", 32'(fifo_count), 0);
    chk("rst irq", 32'(irq_level), 0);
    chk("rst overrun", 32'(overrun), 0);
    chk("rst drops", 32'(drop_count), 0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 8'hA5, 0);
    chk("basic m_valid", 32'(m_valid), 1);
    chk("basic m_data", 32'(m_data), 32'hA5);
    chk("basic count", 32'(fifo_count), 1);
    step(0, 8'h00, 1);
    chk("basic pop valid", 32'(m_valid), 0);
    chk("basic pop count", 32'(fifo_count), 0);

    // Fill / overrun
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(i), 0);
      if (i == 6) chk("irq 7th", 32'(irq_level), 0);
      if (i == 7) chk("irq 8th", 32'(irq_level), 1);
    end
    chk("fill count", 32'(fifo_count), 16);
    chk("fill irq", 32'(irq_level), 1);
    chk("fill overrun", 32'(overrun), 1);
    chk("fill drops", 32'(drop_count), 4);
    for (int i = 0; i < 16; i++) begin
      chk("drain order", 32'(m_data), 32'(i));
      step(0, 8'h00, 1);
    end
    chk("drain empty", 32'(m_valid), 0);

    // Full with simultaneous pop
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0);
    step(1, 8'h30, 1);
    chk("fullpop count", 32'(fifo_count), 16);
    chk("fullpop overrun", 32'(overrun), 0);
    chk("fullpop head", 32'(m_data), 32'h21);
    for (int i = 0; i < 16; i++) begin
      chk("fullpop order", 32'(m_data), 32'(8'h21 + i));
      step(0, 8'h00, 1);
    end

    // Wrap-around stream with ready gaps
    collect = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bit r;
      r = ($urandom_range(0, 3) != 0) || (mq.size() >= 12);
      step(1, 8'(8'h40 + i), r);
    end
    for (int i = 0; i < 40 && m_valid; i++) step(0, 8'h00, 1);
    collect = 1'b0;
    chk("wrap len", 32'(outq.size()), 40);
    for (int i = 0; i < outq.size() && i < 40; i++)
      chk("wrap seq", 32'(outq[i]), 32'(8'h40 + i));
    chk("wrap overrun", 32'(overrun), 0);

    // Saturation / clear-vs-drop
    for (int i = 0; i < 16; i++) step(1, 8'(8'h50 + i), 0);
    for (int i = 0; i < 300; i++) step(1, 8'hEE, 0);
    chk("sat drops", 32'(drop_count), 255);
    chk("sat overrun", 32'(overrun), 1);
    step(1, 8'hEF, 0, 1);
    chk("clrdrop overrun", 32'(overrun), 1);
    chk("clrdrop drops", 32'(drop_count), 1);
    chk("clrdrop head", 32'(m_data), 32'h50);

    // Flush with concurrent byte
    step(0, 8'h00, 0, 1, 1);
    chk("flush1 count", 32'(fifo_count), 0);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h70 + i), 0);
    chk("pre-flush count", 32'(fifo_count), 5);
    step(1, 8'h99, 1, 0, 1);
    chk("flush count", 32'(fifo_count), 0);
    chk("flush valid", 32'(m_valid), 0);
    chk("flush overrun", 32'(overrun), 0);
    chk("flush drops", 32'(drop_count), 0);
    step(1, 8'h3C, 0);
    chk("post-flush head", 32'(m_data), 32'h3C);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 20; i++) step(1, 8'(8'h80 + i), 0);
    chk("pre-rst count", 32'(fifo_count), 16);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(m_valid), 0);
    chk("arst count", 32'(fifo_count), 0);
    chk("arst irq", 32'(irq_level), 0);
    chk("arst overrun", 32'(overrun), 0);
    chk("arst drops", 32'(drop_count), 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 8'h5A, 0);
    chk("after rst data", 32'(m_data), 32'h5A);
    chk("after rst count", 32'(fifo_count), 1);
    step(0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
